// File: rtl/byte_stream_pkg.sv
// byte_stream_pkg: types and helpers shared by the byte-stream link serializer and receiver.
package byte_stream_pkg;
   localparam int BYTE_W = 8;
   typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
   typedef logic [BYTE_W-1:0] byte_t;
   function automatic byte_t xor_reduce_bytes(input byte_t acc, input byte_t b);
      return acc ^ b;
   endfunction
endpackage

// File: rtl/byte_stream_serializer_tx.sv
// byte_stream_serializer_tx: splits NUM_BYTES-wide words into an LSB-first byte stream.
// Define BYTE_STREAM_TX_CHECKSUM_EN to append an XOR checksum byte to every word.
module byte_stream_serializer_tx
   import byte_stream_pkg::*;
#(
   parameter int NUM_BYTES = 4,
   localparam int WORD_W = NUM_BYTES * BYTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [WORD_W-1:0] word_data,
   output byte_t             data_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);
   localparam int IDX_W = NUM_BYTES > 1 ? $clog2(NUM_BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);
   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [WORD_W-1:0]  sreg;
   logic [WORD_W-1:0]  sreg_nxt;
   byte_t              csum_out;
   logic               hs;
   logic               word_hs;
   logic               last_byte;
`ifdef BYTE_STREAM_TX_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
   byte_t csum;
   assign csum_out = xor_reduce_bytes(csum, data_out);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum <= '0;
      else if (word_hs) csum <= '0;
      else if (state == SEND && hs) csum <= csum_out;
   end
`else
   localparam bit CSUM_EN = 1'b0;
   assign csum_out = '0;
`endif
   assign hs        = out_valid & out_ready;
   assign last_byte = idx == LAST_IDX;
   assign sreg_nxt  = sreg >> BYTE_W;
   // Final-byte cycle also accepts the next word so a busy stream has no bubble
   assign word_ready = state == IDLE || (out_ready && (CSUM_EN ? state == CSUM : state == SEND && last_byte));
   assign word_hs    = word_valid & word_ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         sreg      <= '0;
         data_out  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (word_hs) begin
         state     <= SEND;
         idx       <= '0;
         sreg      <= word_data;
         data_out  <= word_data[BYTE_W-1:0];
         out_valid <= 1'b1;
         out_last  <= !CSUM_EN && NUM_BYTES == 1;
      end else if (hs) begin
         if (state == SEND && !last_byte) begin
            idx      <= idx + 1'b1;
            sreg     <= sreg_nxt;
            data_out <= sreg_nxt[BYTE_W-1:0];
            out_last <= !CSUM_EN && (idx + 1'b1 == LAST_IDX);
         end else if (state == SEND && CSUM_EN) begin
            state    <= CSUM;
            data_out <= csum_out;
            out_last <= 1'b1;
         end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_byte_stream_serializer_tx.sv
// tb_byte_stream_serializer_tx: scoreboard bench for the 4-byte serializer plus a 1-byte instance.
module tb_byte_stream_serializer_tx;
   import byte_stream_pkg::*;
`ifdef BYTE_STREAM_TX_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif
   localparam int BPW = 4 + int'(CSUM);
   typedef struct {
      logic [31:0]      word;
      logic [7:0]       mask;
      logic [3:0][7:0]  exp;
   } vec_t;
   logic clk = 0;
   logic rst_n, word_valid, word_ready, out_valid, out_ready, out_last;
   logic [31:0] word_data;
   byte_t data_out;
   logic wv1, wr1, ov1, ol1;
   byte_t wd1, do1;
   int checks = 0, fails = 0;
   logic [8:0] exp_q[$];
   logic [31:0] pend[$];
   logic [8:0] e;
   bit acc = 0;
   vec_t tbl [5];
   always #5 clk = ~clk;
   byte_stream_serializer_tx #(.NUM_BYTES(4)) dut (
      .clk(clk), .rst_n(rst_n), .word_valid(word_valid), .word_ready(word_ready),
      .word_data(word_data), .data_out(data_out), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last));
   byte_stream_serializer_tx #(.NUM_BYTES(1)) u1 (
      .clk(clk), .rst_n(rst_n), .word_valid(wv1), .word_ready(wr1),
      .word_data(wd1), .data_out(do1), .out_valid(ov1),
      .out_ready(1'b1), .out_last(ol1));
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic push_word(input logic [3:0][7:0] b);
      byte_t x = '0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({!CSUM && i == 3, b[i]});
         x ^= b[i];
      end
      if (CSUM) exp_q.push_back({1'b1, x});
   endtask
   task automatic drain(input logic [7:0] mask);
      int n = 0;
      while ((exp_q.size() != 0 || pend.size() != 0 || word_valid || out_valid) && n < 200) begin
         @(posedge clk); #1;
         out_ready = mask[n % 8];
         n++;
      end
      out_ready = 1;
      check("drain_done", n < 200, 1);
      @(negedge clk);
      check("idle_ready", word_ready, 1);
      check("idle_valid", out_valid, 0);
   endtask
   task automatic wait_byte(input byte_t b, input bit last_only);
      bit found = 0;
      for (int n = 0; n < 50 && !found; n++) begin
         @(posedge clk); #1;
         found = out_valid && (last_only ? out_last : data_out == b);
      end
      check("wait_byte", found, 1);
   endtask
   initial begin
      word_valid = 0;
      word_data = '0;
      forever begin
         @(posedge clk); #1;
         if (acc) begin
            acc = 0;
            word_valid = 0;
         end
         if (!word_valid && pend.size() != 0) begin
            word_data = pend.pop_front();
            word_valid = 1;
         end
      end
   end
   always @(negedge clk) if (rst_n && word_valid && word_ready) acc = 1;
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_byte: got %h last %b expected none", data_out, out_last);
         end else begin
            e = exp_q.pop_front();
            check("byte", {23'd0, out_last, data_out}, {23'd0, e});
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      rst_n = 0;
      out_ready = 1;
      wv1 = 0;
      wd1 = '0;
      tbl[0] = '{32'h44332211, 8'hFF, {8'h44, 8'h33, 8'h22, 8'h11}};
      tbl[1] = '{32'hA0B0C0D0, 8'hFF, {8'hA0, 8'hB0, 8'hC0, 8'hD0}};
      tbl[2] = '{32'h01020304, 8'hAA, {8'h01, 8'h02, 8'h03, 8'h04}};
      tbl[3] = '{32'h000000FF, 8'hCC, {8'h00, 8'h00, 8'h00, 8'hFF}};
      tbl[4] = '{32'hDEADBEEF, 8'h5A, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      #3;
      check("rst_valid", out_valid, 0);
      check("rst_data", data_out, 0);
      check("rst_last", out_last, 0);
      check("rst_ready", word_ready, 1);
      @(negedge clk);
      rst_n = 1;
      foreach (tbl[i]) begin
         push_word(tbl[i].exp);
         pend.push_back(tbl[i].word);
         drain(tbl[i].mask);
      end
      // backpressure while 0x22 is presented, then final-byte ready coupling
      push_word({8'h44, 8'h33, 8'h22, 8'h11});
      pend.push_back(32'h44332211);
      wait_byte(8'h22, 0);
      out_ready = 0;
      repeat (3) begin
         @(negedge clk);
         check("stall_data", data_out, 8'h22);
         check("stall_valid", out_valid, 1);
      end
      @(posedge clk); #1;
      out_ready = 1;
      wait_byte(8'h00, 1);
      out_ready = 0;
      @(negedge clk);
      check("final_ready_blocked", word_ready, 0);
      check("final_last_held", out_last, 1);
      @(posedge clk); #1;
      out_ready = 1;
      #1;
      check("final_ready_comb", word_ready, 1);
      drain(8'hFF);
      // back-to-back words with no idle cycle
      push_word({8'hA0, 8'hB0, 8'hC0, 8'hD0});
      pend.push_back(32'hA0B0C0D0);
      push_word({8'h01, 8'h02, 8'h03, 8'h04});
      pend.push_back(32'h01020304);
      wait_byte(8'hD0, 0);
      begin
         int gaps = 0;
         for (int k = 0; k < 2 * BPW; k++) begin
            @(negedge clk);
            if (!out_valid) gaps++;
         end
         check("b2b_gaps", gaps, 0);
      end
      drain(8'hFF);
      // reset in the middle of a word
      push_word({8'h44, 8'h33, 8'h22, 8'h11});
      pend.push_back(32'h44332211);
      wait_byte(8'h11, 0);
      rst_n = 0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_data", data_out, 0);
      check("mid_rst_last", out_last, 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("mid_rst_ready", word_ready, 1);
      rst_n = 1;
      push_word({8'h00, 8'h00, 8'h00, 8'hFF});
      pend.push_back(32'h000000FF);
      wait_byte(8'hFF, 0);
      check("post_rst_first", data_out, 8'hFF);
      drain(8'hFF);
`ifndef BYTE_STREAM_TX_CHECKSUM_EN
      // single-byte words: each byte is last and the next word rides the same handshake
      @(posedge clk); #1;
      wd1 = 8'h5A;
      wv1 = 1;
      @(negedge clk);
      check("nb1_ready_idle", wr1, 1);
      @(posedge clk); #1;
      wd1 = 8'hA5;
      @(negedge clk);
      check("nb1_b0", {ol1, ov1, do1}, {2'b11, 8'h5A});
      check("nb1_same_cycle", wr1, 1);
      @(posedge clk); #1;
      wv1 = 0;
      @(negedge clk);
      check("nb1_b1", {ol1, ov1, do1}, {2'b11, 8'hA5});
      @(posedge clk);
      @(negedge clk);
      check("nb1_idle", ov1, 0);
`endif
      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
